// File: rtl/multicycle_datapath_if.sv
// multicycle_datapath_if
//   Instruction-fetch and data-memory handshake bundle between the multicycle
//   datapath (master) and its memories (slave).
//   instr_req/instr_addr   -> fetch request and word address
//   instr_rdata/instr_valid <- fetched word and its valid strobe
//   mem_req/mem_we/mem_addr/mem_wdata -> data access request, store flag, address, store data
//   mem_rdata/mem_valid    <- load data and access-complete strobe
interface multicycle_datapath_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              instr_req;
    logic [ADDR_W-1:0] instr_addr;
    logic [31:0]       instr_rdata;
    logic              instr_valid;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    modport master (
        output instr_req, instr_addr, mem_req, mem_we, mem_addr, mem_wdata,
        input  instr_rdata, instr_valid, mem_rdata, mem_valid
    );

    modport slave (
        input  instr_req, instr_addr, mem_req, mem_we, mem_addr, mem_wdata,
        output instr_rdata, instr_valid, mem_rdata, mem_valid
    );
endinterface

// File: rtl/multicycle_datapath.sv
// multicycle_datapath
//   Multicycle datapath: register file, ALU, immediate extend, PC logic and
//   the phase FSM that sequences fetch, decode, execute, memory and writeback.
//   The external decoder drives the control inputs from instr_q.
//   clk, rst      clock, asynchronous active-low reset
//   bus           instruction / data memory handshakes (master side)
//   RegSrc .. PCSrc, ImmSrc, ALUControl   decoder controls
//   instr_q       latched instruction
//   ALUFlags      {N,Z,C,V}
//   pc            current PC
//   phase         FSM state (debug)
//
// state  | meaning
// FETCH  | request instruction at pc, latch it on instr_valid
// DECODE | read register operands into A/B (PC alias reads pc+2)
// EXEC   | ALU operation into ALUOut, optional flag update
// MEM    | data access, latch load data on mem_valid
// WB     | register writeback and PC update
module multicycle_datapath #(
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 32,
    parameter int              REG_AW    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter bit              BYTE_LOAD = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_datapath_if.master bus,
    input  logic [1:0]           RegSrc,
    input  logic                 RegWrite,
    input  logic                 FlagWrite,
    input  logic                 ALUSrc,
    input  logic                 MemtoReg,
    input  logic                 MemAccess,
    input  logic                 MemWrite,
    input  logic                 PCSrc,
    input  logic [1:0]           ImmSrc,
    input  logic [1:0]           ALUControl,
    output logic [31:0]          instr_q,
    output logic [3:0]           ALUFlags,
    output logic [ADDR_W-1:0]    pc,
    output logic [2:0]           phase
);
    localparam int NREGS = 2 ** REG_AW;
    localparam logic [REG_AW-1:0] PC_IDX = REG_AW'(NREGS - 1);
    localparam int MSB = DATA_W - 1;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] a_q, b_q, alu_out, load_q;
    logic [REG_AW-1:0] ra1, ra2, a3;
    logic [DATA_W-1:0] pc_plus2, rd1, rd2, ext, src_b, wb_result;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W:0]   sum;
    logic              alu_c, alu_v;

    // Register fields: Rn at [19:16], Rd at [15:12], Rm at [3:0].
    assign ra1 = RegSrc[0] ? PC_IDX : instr_q[16 +: REG_AW];
    assign ra2 = RegSrc[1] ? instr_q[12 +: REG_AW] : instr_q[0 +: REG_AW];
    assign a3  = instr_q[12 +: REG_AW];

    // The top register index is not storage: reads see pc+2, writes are dropped.
    assign pc_plus2 = DATA_W'(pc + ADDR_W'(2));
    assign rd1 = (ra1 == PC_IDX) ? pc_plus2 : regs[ra1];
    assign rd2 = (ra2 == PC_IDX) ? pc_plus2 : regs[ra2];

    always_comb begin
        ext = '0;
        case (ImmSrc)
            2'b00:   ext = DATA_W'(instr_q[7:0]);
            2'b01:   ext = DATA_W'(instr_q[11:0]);
            2'b10:   ext = DATA_W'($signed(instr_q[23:0]));
            default: ext = '0;
        endcase
    end

    assign src_b = ALUSrc ? ext : b_q;

    // Subtract as A + ~B + 1 so the carry out is the "no borrow" flag.
    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControl)
            2'b00: begin
                sum     = {1'b0, a_q} + {1'b0, src_b};
                alu_res = sum[MSB:0];
                alu_c   = sum[DATA_W];
                alu_v   = (a_q[MSB] == src_b[MSB]) && (alu_res[MSB] != a_q[MSB]);
            end
            2'b01: begin
                sum     = {1'b0, a_q} + {1'b0, ~src_b} + {{DATA_W{1'b0}}, 1'b1};
                alu_res = sum[MSB:0];
                alu_c   = sum[DATA_W];
                alu_v   = (a_q[MSB] != src_b[MSB]) && (alu_res[MSB] != a_q[MSB]);
            end
            2'b10:   alu_res = a_q & src_b;
            default: alu_res = a_q | src_b;
        endcase
    end

    assign wb_result      = MemtoReg ? load_q : alu_out;
    assign bus.instr_addr = pc;
    assign bus.mem_addr   = ADDR_W'(alu_out);
    assign bus.mem_wdata  = b_q;
    assign phase          = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            instr_q       <= '0;
            ALUFlags      <= '0;
            a_q           <= '0;
            b_q           <= '0;
            alu_out       <= '0;
            load_q        <= '0;
            bus.instr_req <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    // First FETCH after reset raises the request; a valid seen
                    // before the request is up is ignored.
                    if (!bus.instr_req) begin
                        bus.instr_req <= 1'b1;
                    end else if (bus.instr_valid) begin
                        instr_q       <= bus.instr_rdata;
                        bus.instr_req <= 1'b0;
                        state         <= DECODE;
                    end
                end
                DECODE: begin
                    a_q   <= rd1;
                    b_q   <= rd2;
                    state <= EXEC;
                end
                EXEC: begin
                    alu_out <= alu_res;
                    if (FlagWrite) ALUFlags <= {alu_res[MSB], alu_res == '0, alu_c, alu_v};
                    if (MemAccess) begin
                        bus.mem_req <= 1'b1;
                        bus.mem_we  <= MemWrite;
                        state       <= MEM;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (bus.mem_valid) begin
                        load_q      <= BYTE_LOAD ? DATA_W'(bus.mem_rdata[7:0]) : bus.mem_rdata;
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        state       <= WB;
                    end
                end
                WB: begin
                    if (RegWrite && (a3 != PC_IDX)) regs[a3] <= wb_result;
                    pc            <= PCSrc ? ADDR_W'(wb_result) : pc + ADDR_W'(1);
                    bus.instr_req <= 1'b1;
                    state         <= FETCH;
                end
                default: begin
                    bus.instr_req <= 1'b0;
                    bus.mem_req   <= 1'b0;
                    bus.mem_we    <= 1'b0;
                    state         <= FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_datapath.sv
`timescale 1ns/1ps
module tb_multicycle_datapath;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multicycle_datapath_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [1:0]    RegSrc, ImmSrc, ALUControl;
    logic          RegWrite, FlagWrite, ALUSrc, MemtoReg, MemAccess, MemWrite, PCSrc;
    logic [31:0]   instr_q;
    logic [3:0]    ALUFlags;
    logic [AW-1:0] pc;
    logic [2:0]    phase;

    multicycle_datapath dut (
        .clk(clk), .rst(rst), .bus(bus.master),
        .RegSrc(RegSrc), .RegWrite(RegWrite), .FlagWrite(FlagWrite), .ALUSrc(ALUSrc),
        .MemtoReg(MemtoReg), .MemAccess(MemAccess), .MemWrite(MemWrite), .PCSrc(PCSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .instr_q(instr_q), .ALUFlags(ALUFlags), .pc(pc), .phase(phase)
    );

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  regsrc, immsrc, aluc;
        logic [6:0]  ctl;
        int          fwait, mwait;
        logic [31:0] ld;
    } op_t;
    typedef struct { logic [31:0] addr, wdata; logic we; } mem_exp_t;
    typedef struct { logic [31:0] pc, instr; logic [3:0] flags; bit mem; } ret_t;

    // ctl bit positions
    localparam logic [6:0] RW = 7'b1000000, FW = 7'b0100000, AS = 7'b0010000,
                           MR = 7'b0001000, MA = 7'b0000100, MW = 7'b0000010,
                           PS = 7'b0000001;

    op_t      prog[$];
    mem_exp_t mem_q[$];
    ret_t     ret_q[$];

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0, hold = 1'b0, late_valid = 1'b0;

    logic [31:0] mregs [16];
    logic [31:0] mpc;
    logic [3:0]  mflags;

    op_t         cur;
    bit          in_fetch, in_mem;
    int          fcnt, mcnt;
    logic [31:0] fetch_pc;
    logic [2:0]  prev_phase = 3'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic op_t mk(input logic [31:0] instr, input logic [1:0] rs,
                               input logic [1:0] is, input logic [1:0] ac,
                               input logic [6:0] ctl, input int fw, input int mw,
                               input logic [31:0] ld);
        op_t o;
        o.instr = instr; o.regsrc = rs; o.immsrc = is; o.aluc = ac;
        o.ctl = ctl; o.fwait = fw; o.mwait = mw; o.ld = ld;
        return o;
    endfunction

    function automatic logic [31:0] rv(input int i);
        return (i == 15) ? mpc + 32'd2 : mregs[i];
    endfunction

    // Reference: architectural effect of one instruction, in plain arithmetic.
    task automatic model(input op_t e);
        int rn, rd, rm;
        logic [31:0] a, b, imm, op2, r, res;
        longint sa, sb, sr;
        bit c, v;
        mem_exp_t me;
        ret_t rt;
        rn = int'(e.instr[19:16]);
        rd = int'(e.instr[15:12]);
        rm = int'(e.instr[3:0]);
        a = e.regsrc[0] ? mpc + 32'd2 : rv(rn);
        b = e.regsrc[1] ? rv(rd) : rv(rm);
        case (e.immsrc)
            2'd0:    imm = 32'(e.instr[7:0]);
            2'd1:    imm = 32'(e.instr[11:0]);
            2'd2:    imm = 32'($signed(e.instr[23:0]));
            default: imm = 32'd0;
        endcase
        op2 = e.ctl[4] ? imm : b;
        sa = longint'($signed(a));
        sb = longint'($signed(op2));
        c = 1'b0; v = 1'b0;
        case (e.aluc)
            2'd0: begin
                r = a + op2;
                c = (longint'(a) + longint'(op2)) > 64'sd4294967295;
                sr = sa + sb;
                v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            2'd1: begin
                r = a - op2;
                c = (a >= op2);
                sr = sa - sb;
                v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            2'd2:    r = a & op2;
            default: r = a | op2;
        endcase
        if (e.ctl[5]) mflags = {r[31], r == 32'd0, c, v};
        if (e.ctl[2]) begin
            me.addr = r; me.wdata = b; me.we = e.ctl[1];
            mem_q.push_back(me);
        end
        res = e.ctl[3] ? {24'd0, e.ld[7:0]} : r;
        if (e.ctl[6] && rd != 15) mregs[rd] = res;
        mpc = e.ctl[0] ? res : mpc + 32'd1;
        rt.pc = mpc; rt.instr = e.instr; rt.flags = mflags; rt.mem = e.ctl[2];
        ret_q.push_back(rt);
    endtask

    // Instruction memory: serves program entries with per-entry wait states
    // and applies that entry's decoder controls.
    initial begin : ifetch
        bus.instr_valid = 1'b0; bus.instr_rdata = '0;
        RegSrc = '0; ImmSrc = '0; ALUControl = '0;
        {RegWrite, FlagWrite, ALUSrc, MemtoReg, MemAccess, MemWrite, PCSrc} = '0;
        in_fetch = 1'b0; fcnt = 0; fetch_pc = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst || hold) begin
                bus.instr_valid = 1'b0; in_fetch = 1'b0;
            end else if (bus.instr_req) begin
                if (!in_fetch && prog.size() > 0) begin
                    cur = prog.pop_front();
                    in_fetch = 1'b1; fcnt = cur.fwait; fetch_pc = mpc;
                    RegSrc = cur.regsrc; ImmSrc = cur.immsrc; ALUControl = cur.aluc;
                    {RegWrite, FlagWrite, ALUSrc, MemtoReg, MemAccess, MemWrite, PCSrc} = cur.ctl;
                    if (mon_en) begin
                        chk("fetch_addr", 64'(bus.instr_addr), 64'(mpc));
                        model(cur);
                    end
                end else if (in_fetch && mon_en) begin
                    chk("fetch_addr_hold", 64'(bus.instr_addr), 64'(fetch_pc));
                    chk("pc_hold", 64'(pc), 64'(fetch_pc));
                end
                if (in_fetch && fcnt == 0) begin
                    bus.instr_valid = 1'b1; bus.instr_rdata = cur.instr;
                end else begin
                    if (in_fetch) fcnt--;
                    bus.instr_valid = 1'b0; bus.instr_rdata = $urandom;
                end
            end else begin
                bus.instr_valid = 1'b0; in_fetch = 1'b0;
            end
        end
    end

    // Data memory: acks after the entry's wait count, returns its load word.
    initial begin : dmem
        bus.mem_valid = 1'b0; bus.mem_rdata = '0; in_mem = 1'b0; mcnt = 0;
        forever begin
            @(posedge clk); #1;
            if (late_valid) begin
                bus.mem_valid = 1'b1; bus.mem_rdata = $urandom;
            end else if (!rst) begin
                bus.mem_valid = 1'b0; in_mem = 1'b0;
            end else if (bus.mem_req) begin
                if (!in_mem) begin in_mem = 1'b1; mcnt = cur.mwait; end
                if (mcnt == 0) begin
                    bus.mem_valid = 1'b1; bus.mem_rdata = cur.ld;
                end else begin
                    mcnt--; bus.mem_valid = 1'b0; bus.mem_rdata = $urandom;
                end
            end else begin
                bus.mem_valid = 1'b0; in_mem = 1'b0;
            end
        end
    end

    // Monitor: pops expectations on data accesses, phase changes and retirement.
    always @(negedge clk) begin
        mem_exp_t me;
        ret_t rt;
        logic [2:0] exp_ph;
        if (mon_en && rst) begin
            if (bus.mem_req && bus.mem_valid) begin
                if (mem_q.size() == 0) chk("mem_unexpected", 64'(1), 64'(0));
                else begin
                    me = mem_q.pop_front();
                    chk("mem_addr", 64'(bus.mem_addr), 64'(me.addr));
                    chk("mem_we", 64'(bus.mem_we), 64'(me.we));
                    if (me.we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(me.wdata));
                end
            end
            if (phase != prev_phase) begin
                if (ret_q.size() == 0) chk("phase_no_instr", 64'(phase), 64'(prev_phase));
                else begin
                    case (prev_phase)
                        3'd0:    exp_ph = 3'd1;
                        3'd1:    exp_ph = 3'd2;
                        3'd2:    exp_ph = ret_q[0].mem ? 3'd3 : 3'd4;
                        3'd3:    exp_ph = 3'd4;
                        default: exp_ph = 3'd0;
                    endcase
                    chk("phase_seq", 64'(phase), 64'(exp_ph));
                    if (prev_phase == 3'd4) begin
                        rt = ret_q.pop_front();
                        chk("retire_pc", 64'(pc), 64'(rt.pc));
                        chk("retire_flags", 64'(ALUFlags), 64'(rt.flags));
                        chk("retire_instr_q", 64'(instr_q), 64'(rt.instr));
                    end
                end
            end
        end
        prev_phase = phase;
    end

    initial begin : main
        op_t o;
        bit seen;
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        mpc = '0; mflags = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_phase", 64'(phase), 64'(0));
        chk("rst_pc", 64'(pc), 64'(0));
        chk("rst_instr_q", 64'(instr_q), 64'(0));
        chk("rst_flags", 64'(ALUFlags), 64'(0));
        chk("rst_instr_req", 64'(bus.instr_req), 64'(0));
        chk("rst_mem_req", 64'(bus.mem_req), 64'(0));
        chk("rst_mem_we", 64'(bus.mem_we), 64'(0));

        prog.push_back(mk(32'h0000_1005, 2'b00, 2'b00, 2'b00, RW|AS, 0, 0, 0));          // ADD R1,R0,#5
        prog.push_back(mk(32'h0000_1000, 2'b10, 2'b00, 2'b00, AS|MA|MW, 0, 1, 0));       // STR R1,[R0]
        prog.push_back(mk(32'h0000_2003, 2'b00, 2'b00, 2'b00, RW|AS, 0, 0, 0));          // R2=3
        prog.push_back(mk(32'h0000_3005, 2'b00, 2'b00, 2'b00, RW|AS, 3, 0, 0));          // R3=5, slow fetch
        prog.push_back(mk(32'h0002_4003, 2'b00, 2'b00, 2'b01, RW|FW, 0, 0, 0));          // SUB 3-5
        prog.push_back(mk(32'h0003_4003, 2'b00, 2'b00, 2'b01, RW|FW, 0, 0, 0));          // SUB 5-5
        prog.push_back(mk(32'h0000_5004, 2'b00, 2'b00, 2'b00, RW|AS|MA|MR, 1, 2, 32'hDEADBEEF));
        prog.push_back(mk(32'h0000_5008, 2'b10, 2'b00, 2'b00, AS|MA|MW, 0, 0, 0));       // STR R5
        prog.push_back(mk(32'h0000_0040, 2'b00, 2'b00, 2'b00, AS|PS, 0, 0, 0));          // B 0x40
        prog.push_back(mk(32'h0000_0008, 2'b00, 2'b00, 2'b00, AS|PS, 0, 0, 0));          // B 8
        prog.push_back(mk(32'h0000_6000, 2'b01, 2'b00, 2'b00, RW|AS, 0, 0, 0));          // R6=PC alias
        prog.push_back(mk(32'h0000_6000, 2'b10, 2'b00, 2'b00, AS|MA|MW, 0, 0, 0));       // STR R6
        prog.push_back(mk(32'h0000_F007, 2'b00, 2'b00, 2'b00, RW|AS, 0, 0, 0));          // write R15 dropped
        prog.push_back(mk(32'h00FF_FFFF, 2'b00, 2'b10, 2'b11, AS|PS, 0, 0, 0));          // B 0xFFFFFFFF
        prog.push_back(mk(32'h0000_0000, 2'b00, 2'b00, 2'b00, 7'd0, 0, 0, 0));           // wrap to 0
        prog.push_back(mk(32'h0000_F000, 2'b10, 2'b00, 2'b00, AS|MA|MW, 0, 0, 0));       // STR R15 alias
        for (int i = 0; i < 80; i++) begin
            o.instr = $urandom; o.regsrc = 2'($urandom_range(0, 3));
            o.immsrc = 2'($urandom_range(0, 3)); o.aluc = 2'($urandom_range(0, 3));
            o.ctl = '0;
            o.ctl[6] = ($urandom_range(0, 3) != 0);
            o.ctl[5] = $urandom_range(0, 1) == 1;
            o.ctl[4] = $urandom_range(0, 1) == 1;
            o.ctl[2] = ($urandom_range(0, 2) == 0);
            o.ctl[1] = o.ctl[2] && ($urandom_range(0, 1) == 1);
            o.ctl[3] = o.ctl[2] && !o.ctl[1] && ($urandom_range(0, 1) == 1);
            o.ctl[0] = ($urandom_range(0, 7) == 0);
            o.fwait = $urandom_range(0, 3); o.mwait = $urandom_range(0, 3); o.ld = $urandom;
            prog.push_back(o);
        end

        mon_en = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 20000 && (prog.size() > 0 || ret_q.size() > 0); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("drain_prog", 64'(prog.size()), 64'(0));
        chk("drain_retire", 64'(ret_q.size()), 64'(0));
        chk("drain_mem", 64'(mem_q.size()), 64'(0));

        // Reset while a data request is outstanding, then a stray late valid.
        mon_en = 1'b0;
        prog.push_back(mk(32'h0000_0010, 2'b00, 2'b00, 2'b00, AS|MA, 0, 50, 0));
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mem_req;
        end
        chk("mem_req_seen", 64'(seen), 64'(1));
        #2 rst = 1'b0;
        #1;
        chk("rstmid_mem_req", 64'(bus.mem_req), 64'(0));
        chk("rstmid_pc", 64'(pc), 64'(0));
        chk("rstmid_phase", 64'(phase), 64'(0));
        chk("rstmid_instr_req", 64'(bus.instr_req), 64'(0));
        hold = 1'b1;
        late_valid = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("late_valid_phase", 64'(phase), 64'(0));
            chk("late_valid_mem_req", 64'(bus.mem_req), 64'(0));
        end
        chk("late_valid_pc", 64'(pc), 64'(0));
        late_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
